push_switch_debounce: RTL and testbench

Conditions the 4 raw active-high push switches on the FM kit before any logic uses them.
- Per-channel 2-FF synchroniser, counter-based debounce, and press/release edge detection.
- A per-switch toggle latch drives the 4 active-low LEDs.
- Sits between the switch pins and user logic/LEDs, replacing direct combinational switch-to-LED wiring.

---
 rtl/push_switch_pkg.sv | 21 ++
 rtl/switch_debounce_ch.sv | 93 +++++++++
 rtl/push_switch_debounce.sv | 64 ++++++
 tb/tb_push_switch_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/push_switch_pkg.sv
// Shared constants, timing helper and debounce event type for the push-switch conditioner.
package push_switch_pkg;

  localparam int CLK_HZ          = 12000000;
  localparam int DB_MS_DEFAULT   = 10;
  localparam int LONG_MS_DEFAULT = 1000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DB_CYCLES_DEFAULT   = ms_to_cycles(DB_MS_DEFAULT);
  localparam int LONG_CYCLES_DEFAULT = ms_to_cycles(LONG_MS_DEFAULT);

  typedef enum logic [1:0] {
    EV_NONE,
    EV_PRESS,
    EV_RELEASE
  } sw_event_e;

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: 2-FF synchroniser, stable-count debounce and registered edge strobes.
// PUSH_SWITCH_LONG_PRESS_EN adds a saturating hold counter and a one-shot long-press strobe.
module switch_debounce_ch
  import push_switch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
`ifdef PUSH_SWITCH_LONG_PRESS_EN
  , parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_level,
  output logic press_pulse,
  output logic release_pulse
`ifdef PUSH_SWITCH_LONG_PRESS_EN
  , output logic long_press_pulse
`endif
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync_p0, sync_p1;
  logic [CW-1:0] cnt;
  logic          accept;
  sw_event_e     ev_next;

  // stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    accept  = (sync_p1 != sw_level) && (cnt == DB_LAST);
    ev_next = EV_NONE;
    if (accept) begin
      ev_next = sync_p1 ? EV_PRESS : EV_RELEASE;
    end
  end

  // debounce stage: any agreement with the current level throws away the partial count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      sw_level      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      if ((sync_p1 == sw_level) || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        sw_level <= sync_p1;
      end
      press_pulse   <= (ev_next == EV_PRESS);
      release_pulse <= (ev_next == EV_RELEASE);
    end
  end

`ifdef PUSH_SWITCH_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

  logic [HW-1:0] hold;

  // the strobe is raised on the edge the counter reaches its saturation value, so it fires once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold             <= '0;
      long_press_pulse <= 1'b0;
    end else begin
      if (!sw_level) begin
        hold <= '0;
      end else if (hold != HOLD_LAST) begin
        hold <= hold + HW'(1);
      end
      long_press_pulse <= sw_level && (hold == HOLD_FIRE);
    end
  end
`endif

endmodule

// File: rtl/push_switch_debounce.sv
// Conditions N_SW raw push switches and drives toggle-on-press active-low LEDs.
// PUSH_SWITCH_LONG_PRESS_EN adds LONG_CYCLES, long_press_pulse and long-press LED clear.
module push_switch_debounce
  import push_switch_pkg::*;
#(
  parameter int N_SW      = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
`ifdef PUSH_SWITCH_LONG_PRESS_EN
  , parameter int LONG_CYCLES = LONG_CYCLES_DEFAULT
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] press_pulse,
  output logic [N_SW-1:0] release_pulse,
  output logic [N_SW-1:0] led_n
`ifdef PUSH_SWITCH_LONG_PRESS_EN
  , output logic [N_SW-1:0] long_press_pulse
`endif
);

  logic [N_SW-1:0] toggle, toggle_next;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    switch_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES)
`ifdef PUSH_SWITCH_LONG_PRESS_EN
      , .LONG_CYCLES (LONG_CYCLES)
`endif
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .sw            (sw[i]),
      .sw_level      (sw_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
`ifdef PUSH_SWITCH_LONG_PRESS_EN
      , .long_press_pulse (long_press_pulse[i])
`endif
    );
  end

  always_comb begin
`ifdef PUSH_SWITCH_LONG_PRESS_EN
    toggle_next = (toggle ^ press_pulse) & ~long_press_pulse;
`else
    toggle_next = toggle ^ press_pulse;
`endif
  end

  // toggle stage: follows the press strobe by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= '0;
    end else begin
      toggle <= toggle_next;
    end
  end

  assign led_n = ~toggle;

endmodule

// File: tb/tb_push_switch_debounce.sv
// Scoreboard bench for push_switch_debounce: a window-based reference model queues the
// expected outputs for every clock edge and a separate monitor compares them.
module tb_push_switch_debounce;

  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int LONG = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw  = '0;
  logic [N-1:0] sw_level, press_pulse, release_pulse, led_n;
`ifdef PUSH_SWITCH_LONG_PRESS_EN
  logic [N-1:0] long_press_pulse;
`endif

  push_switch_debounce #(
    .N_SW      (N),
    .DB_CYCLES (DB)
`ifdef PUSH_SWITCH_LONG_PRESS_EN
    , .LONG_CYCLES (LONG)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .sw_level      (sw_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .led_n         (led_n)
`ifdef PUSH_SWITCH_LONG_PRESS_EN
    , .long_press_pulse (long_press_pulse)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] led;
    logic [N-1:0] lp;
  } exp_t;

  exp_t         expq[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl = '0, m_pr = '0, m_rl = '0, m_tog = '0, m_lp = '0;
  logic [N-1:0] n_pr, n_rl, n_lp;
  int           cyc = 0;
  int           rise_cyc[N];
  bit           stable;
  int           checks = 0;
  int           fails  = 0;

  // Reference model: a channel flips when the DB synchronised samples seen by the
  // debouncer (raw samples taken 2..DB+1 edges ago) all disagree with its level.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      hist = {};
      repeat (DB + 2) hist.push_back('0);
      m_lvl = '0; m_pr = '0; m_rl = '0; m_tog = '0; m_lp = '0;
    end else begin
      m_tog = (m_tog ^ m_pr) & ~m_lp;
      hist.push_back(sw);
      void'(hist.pop_front());
      n_pr = '0; n_rl = '0; n_lp = '0;
      for (int ch = 0; ch < N; ch++) begin
        stable = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (hist[k][ch] == m_lvl[ch]) stable = 1'b0;
        end
`ifdef PUSH_SWITCH_LONG_PRESS_EN
        n_lp[ch] = m_lvl[ch] && ((cyc - rise_cyc[ch]) == LONG - 1);
`endif
        if (stable) begin
          n_pr[ch] = ~m_lvl[ch];
          n_rl[ch] = m_lvl[ch];
          m_lvl[ch] = ~m_lvl[ch];
          if (m_lvl[ch]) rise_cyc[ch] = cyc;
        end
      end
      m_pr = n_pr; m_rl = n_rl; m_lp = n_lp;
    end
    expq.push_back('{lvl: m_lvl, pr: m_pr, rl: m_rl, led: ~m_tog, lp: m_lp});
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty at cycle %0d: got 0 entries, expected 1", cyc);
      end else begin
        e = expq.pop_front();
        check("sw_level", sw_level, e.lvl);
        check("press_pulse", press_pulse, e.pr);
        check("release_pulse", release_pulse, e.rl);
        check("led_n", led_n, e.led);
`ifdef PUSH_SWITCH_LONG_PRESS_EN
        check("long_press_pulse", long_press_pulse, e.lp);
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int run[N];

  initial begin
    // reset with all switches pressed
    rst = 1'b1; sw = '1;
    step(5);
    sw = '0;
    step(2);
    rst = 1'b0;
    step(4);
    // clean press and release
    sw[0] = 1'b1; step(20);
    sw[0] = 1'b0; step(20);
    // bouncing press
    sw[1] = 1'b1; step(3); sw[1] = 1'b0; step(3);
    sw[1] = 1'b1; step(3); sw[1] = 1'b0; step(3);
    sw[1] = 1'b1; step(20);
    sw[1] = 1'b0; step(20);
    // glitch one short of acceptance, then exactly at acceptance
    sw[2] = 1'b1; step(DB - 1); sw[2] = 1'b0; step(20);
    sw[2] = 1'b1; step(DB);     sw[2] = 1'b0; step(20);
    // simultaneous presses, twice
    sw = '1; step(20); sw = '0; step(20);
    sw = '1; step(20); sw = '0; step(20);
    // reset mid-debounce with sw[3] held
    sw[3] = 1'b1; step(7);
    rst = 1'b1; step(2);
    rst = 1'b0; step(LONG + 20);
    sw[3] = 1'b0; step(20);
    // randomized bouncing on all channels with occasional resets
    for (int ch = 0; ch < N; ch++) run[ch] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (run[ch] == 0) begin
          sw[ch]  = ~sw[ch];
          run[ch] = (($urandom % 3) == 0) ? $urandom_range(DB, LONG + 10)
                                          : $urandom_range(1, 2 * DB);
        end
        run[ch]--;
      end
      rst = (($urandom % 600) == 0);
      step(1);
    end
    rst = 1'b0;
    step(3);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
